field_renderer: RTL and testbench

- Parametrised playfield store and pixel renderer for the Tetris VGA path.
- Holds the locked-piece colour grid internally: cell writes from game logic, plus a self-timed line-clear sequence (scan, flash, collapse).
- Emits wall/field/cell RGB per pixel through a fixed 2-cycle pipeline; sits between game control and the colour mapper, below the falling-shape and boundary layers.

---
 rtl/field_renderer.sv | 214 +++++++++++++++++++++
 tb/tb_field_renderer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/field_renderer.sv
// rtl/field_renderer.sv - Tetris playfield store, line-clear sequencer and 2-stage pixel renderer
// Optional macro FIELD_GRID_LINES_EN: empty cells draw 404040 on their last pixel row/column.
module field_renderer #(
  parameter int          COLS         = 10,
  parameter int          ROWS         = 20,
  parameter int          CELL         = 24,
  parameter int          FIELD_X0     = 210,
  parameter int          FIELD_Y0     = 0,
  parameter int          WALL_W       = 20,
  parameter int          CODE_W       = 3,
  parameter logic [23:0] FLASH_CYCLES = 24'd6000000,
  localparam int         RW           = $clog2(ROWS),
  localparam int         CW           = $clog2(COLS),
  localparam int         LW           = $clog2(ROWS + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              is_shape,
  input  logic              is_boundary,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [LW-1:0]     lines_cleared,
  output logic              is_background,
  output logic [7:0]        backRed,
  output logic [7:0]        backGreen,
  output logic [7:0]        backBlue
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLASH, S_COLLAPSE, S_DONE} state_t;
  typedef enum logic [1:0] {R_OUT, R_WALL, R_FG, R_FIELD} region_t;

  logic [CODE_W-1:0] grid [ROWS][COLS];
  state_t            state;
  logic [ROWS-1:0]   full_mask, mask_n;
  logic [RW-1:0]     scan_row, dst, src_idx;
  int                src, src_eff;
  logic [23:0]       flash_cnt;
  logic              row_full;
  logic [LW-1:0]     lines_n;

  function automatic logic [23:0] palette(input logic [CODE_W-1:0] code);
    case (int'(code))
      0:       palette = 24'h000000;
      1:       palette = 24'h00FFFF;
      2:       palette = 24'hFFFF00;
      3:       palette = 24'h800080;
      4:       palette = 24'h00FF00;
      5:       palette = 24'hFF0000;
      6:       palette = 24'h0000FF;
      7:       palette = 24'hFFA500;
      default: palette = 24'h808080;
    endcase
  endfunction

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (grid[scan_row][c] == '0) row_full = 1'b0;
    mask_n = full_mask | (ROWS'(row_full) << scan_row);
    lines_n = '0;
    for (int r = 0; r < ROWS; r++) lines_n = lines_n + LW'(full_mask[r]);
    // Nearest unflagged row at or above src; -1 means the field above is exhausted.
    src_eff = -1;
    for (int r = 0; r < ROWS; r++)
      if (r <= src && !full_mask[r]) src_eff = r;
    src_idx = RW'(src_eff);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
      lines_cleared <= '0;
      full_mask     <= '0;
      scan_row      <= '0;
      dst           <= '0;
      src           <= 0;
      flash_cnt     <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) grid[r][c] <= '0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS)
            grid[wr_row][wr_col] <= wr_code;
          if (clear_start) begin
            state      <= S_SCAN;
            clear_busy <= 1'b1;
            scan_row   <= RW'(ROWS - 1);
            full_mask  <= '0;
          end
        end
        S_SCAN: begin
          full_mask <= mask_n;
          if (scan_row == '0) begin
            if (mask_n == '0) begin
              state         <= S_DONE;
              clear_done    <= 1'b1;
              lines_cleared <= '0;
            end else begin
              state     <= S_FLASH;
              flash_cnt <= '0;
            end
          end else begin
            scan_row <= scan_row - RW'(1);
          end
        end
        S_FLASH: begin
          if (flash_cnt == FLASH_CYCLES - 24'd1) begin
            state <= S_COLLAPSE;
            dst   <= RW'(ROWS - 1);
            src   <= ROWS - 1;
          end else begin
            flash_cnt <= flash_cnt + 24'd1;
          end
        end
        S_COLLAPSE: begin
          for (int c = 0; c < COLS; c++)
            grid[dst][c] <= (src_eff >= 0) ? grid[src_idx][c] : '0;
          src <= src_eff - 1;
          if (dst == '0) begin
            state         <= S_DONE;
            clear_done    <= 1'b1;
            lines_cleared <= lines_n;
          end else begin
            dst <= dst - RW'(1);
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          clear_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  int            rx, ry;
  region_t       rgn_n, s1_rgn;
  logic [RW-1:0] row_n, s1_row;
  logic [CW-1:0] col_n, s1_col;
  logic [23:0]   field_rgb, rgb;

  // Cell index found by comparing against cell boundaries rather than dividing.
  always_comb begin
    rx = int'(DrawX) - FIELD_X0;
    ry = int'(DrawY) - FIELD_Y0;
    row_n = '0;
    col_n = '0;
    for (int i = 1; i < ROWS; i++) if (ry >= i * CELL) row_n = RW'(i);
    for (int i = 1; i < COLS; i++) if (rx >= i * CELL) col_n = CW'(i);
    if ((ry >= 0) && (ry < ROWS * CELL) &&
        (((rx >= -WALL_W) && (rx < 0)) || ((rx >= COLS * CELL) && (rx < COLS * CELL + WALL_W))))
      rgn_n = R_WALL;
    else if (is_shape || is_boundary)
      rgn_n = R_FG;
    else if ((ry >= 0) && (ry < ROWS * CELL) && (rx >= 0) && (rx < COLS * CELL))
      rgn_n = R_FIELD;
    else
      rgn_n = R_OUT;
  end

`ifdef FIELD_GRID_LINES_EN
  logic grid_edge_n, s1_grid_edge;
  always_comb begin
    grid_edge_n = 1'b0;
    for (int i = 0; i < COLS; i++) if (rx == i * CELL + CELL - 1) grid_edge_n = 1'b1;
    for (int i = 0; i < ROWS; i++) if (ry == i * CELL + CELL - 1) grid_edge_n = 1'b1;
  end
  always_ff @(posedge Clk) s1_grid_edge <= Reset ? 1'b0 : grid_edge_n;
`endif

  always_comb begin
    if (state == S_FLASH && full_mask[s1_row])
      field_rgb = 24'hFFFFFF;
`ifdef FIELD_GRID_LINES_EN
    else if (grid[s1_row][s1_col] == '0 && s1_grid_edge)
      field_rgb = 24'h404040;
`endif
    else
      field_rgb = palette(grid[s1_row][s1_col]);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_rgn        <= R_OUT;
      s1_row        <= '0;
      s1_col        <= '0;
      is_background <= 1'b0;
      rgb           <= '0;
    end else begin
      s1_rgn <= rgn_n;
      s1_row <= row_n;
      s1_col <= col_n;
      case (s1_rgn)
        R_WALL:  begin is_background <= 1'b1; rgb <= 24'h87CEEB; end
        R_FIELD: begin is_background <= 1'b1; rgb <= field_rgb;  end
        default: begin is_background <= 1'b0; rgb <= 24'hFFFFFF; end
      endcase
    end
  end

  assign {backRed, backGreen, backBlue} = rgb;

endmodule

// File: tb/tb_field_renderer.sv
// tb/tb_field_renderer.sv - table-driven, scoreboarded bench for field_renderer
module tb_field_renderer;
  localparam int          ROWS  = 20;
  localparam int          COLS  = 10;
  localparam int          CELL  = 24;
  localparam int          X0    = 210;
  localparam logic [23:0] FLASH = 24'd8;

  logic       Clk = 1'b0, Reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       is_shape = 1'b0, is_boundary = 1'b0, wr_en = 1'b0, clear_start = 1'b0;
  logic [4:0] wr_row = '0;
  logic [3:0] wr_col = '0;
  logic [2:0] wr_code = '0;
  logic       clear_busy, clear_done, is_background;
  logic [4:0] lines_cleared;
  logic [7:0] backRed, backGreen, backBlue;

  field_renderer #(.FLASH_CYCLES(FLASH)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .is_shape(is_shape), .is_boundary(is_boundary),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_code(wr_code),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .lines_cleared(lines_cleared), .is_background(is_background),
    .backRed(backRed), .backGreen(backGreen), .backBlue(backBlue)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0]  x, y;
    logic        shape, bound, bg;
    logic [23:0] rgb;
  } pix_t;

  pix_t vecs[$];
  pix_t expq[$];
  int   total = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic pix_t mk(input int x, input int y, input bit sh, input bit bd,
                              input bit bg, input logic [23:0] rgb);
    pix_t p;
    p.x = 10'(x); p.y = 10'(y); p.shape = sh; p.bound = bd; p.bg = bg; p.rgb = rgb;
    return p;
  endfunction

  function automatic pix_t cell_px(input int r, input int c, input logic [23:0] rgb);
    return mk(X0 + c * CELL + 3, r * CELL + 3, 1'b0, 1'b0, 1'b1, rgb);
  endfunction

  // One pixel per cycle; each expectation is popped two cycles after it was pushed.
  task automatic run_stream();
    pix_t p, e;
    int n;
    n = vecs.size();
    expq.delete();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge Clk);
      if (k >= 2) begin
        e = expq.pop_front();
        check($sformatf("pix(%0d,%0d,s%0d,b%0d)", e.x, e.y, e.shape, e.bound),
              {7'd0, is_background, backRed, backGreen, backBlue}, {7'd0, e.bg, e.rgb});
      end
      if (k < n) begin
        p = vecs[k];
        DrawX = p.x; DrawY = p.y; is_shape = p.shape; is_boundary = p.bound;
        expq.push_back(p);
      end
    end
    is_shape = 1'b0; is_boundary = 1'b0;
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk); Reset = 1'b0;
  endtask

  task automatic write_cell(input int r, input int c, input int code);
    @(negedge Clk);
    wr_en = 1'b1; wr_row = 5'(r); wr_col = 4'(c); wr_code = 3'(code);
    @(negedge Clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(output int t0);
    @(negedge Clk); clear_start = 1'b1;
    @(negedge Clk); clear_start = 1'b0;
    t0 = cyc;
    check("busy_after_start", clear_busy, 1);
  endtask

  task automatic wait_done(input string tag, input int t0, input int exp_lat, input int exp_lines);
    int n = 0;
    while (clear_done !== 1'b1 && n < 500) begin @(negedge Clk); n++; end
    check({tag, "_done_seen"}, clear_done, 1);
    check({tag, "_latency"}, cyc - t0, exp_lat);
    check({tag, "_lines"}, lines_cleared, exp_lines);
    @(negedge Clk);
    check({tag, "_done_pulse"}, clear_done, 0);
    check({tag, "_busy_low"}, clear_busy, 0);
  endtask

  task automatic expect_rows_empty(input int r_lo, input int r_hi);
    for (int r = r_lo; r <= r_hi; r++)
      for (int c = 0; c < COLS; c++) vecs.push_back(cell_px(r, c, 24'h000000));
    run_stream();
  endtask

  localparam int FULL_LAT = 2 * ROWS + 8;

  initial begin
    pix_t tbl[14];
    int t0;
    logic [23:0] pal[8];
    tbl[0]  = mk(200,   5, 0, 0, 1, 24'h87CEEB);
    tbl[1]  = mk(215,   5, 0, 0, 1, 24'h000000);
    tbl[2]  = mk(100,   5, 0, 0, 0, 24'hFFFFFF);
    tbl[3]  = mk(455,   5, 0, 0, 1, 24'h87CEEB);
    tbl[4]  = mk(215,   5, 1, 0, 0, 24'hFFFFFF);
    tbl[5]  = mk(200,   5, 1, 0, 1, 24'h87CEEB);
    tbl[6]  = mk(215,   5, 0, 1, 0, 24'hFFFFFF);
    tbl[7]  = mk(189,   5, 0, 0, 0, 24'hFFFFFF);
    tbl[8]  = mk(470,   5, 0, 0, 0, 24'hFFFFFF);
    tbl[9]  = mk(449, 479, 0, 0, 1, 24'h000000);
    tbl[10] = mk(450, 479, 0, 0, 1, 24'h87CEEB);
    tbl[11] = mk(209, 100, 0, 0, 1, 24'h87CEEB);
    tbl[12] = mk(215, 480, 0, 0, 0, 24'hFFFFFF);
    tbl[13] = mk(210,   0, 0, 0, 1, 24'h000000);
    pal = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'h800080,
            24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFA500};

    @(negedge Clk); @(negedge Clk);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_bg", is_background, 0);
    check("rst_rgb", {backRed, backGreen, backBlue}, 0);
    Reset = 1'b0;

    for (int i = 0; i < 14; i++) vecs.push_back(tbl[i]);
    run_stream();

    for (int c = 0; c < 7; c++) write_cell(0, c, c + 1);
    for (int c = 0; c < 8; c++) vecs.push_back(cell_px(0, c, pal[(c + 1) % 8]));
    run_stream();

    do_reset();
    write_cell(19, 0, 5);
    write_cell(20, 1, 3);
    vecs.push_back(cell_px(19, 0, 24'hFF0000));
    vecs.push_back(mk(X0 + 3, 19 * CELL + 3, 1, 0, 0, 24'hFFFFFF));
    vecs.push_back(cell_px(19, 0, 24'hFF0000));
    vecs.push_back(cell_px(19, 1, 24'h000000));
    run_stream();

    // One full bottom row below a single coloured cell.
    do_reset();
    for (int c = 0; c < COLS; c++) write_cell(19, c, 1);
    write_cell(18, 0, 2);
    pulse_start(t0);
    repeat (ROWS) @(negedge Clk);
    vecs.push_back(cell_px(19, 5, 24'hFFFFFF));
    vecs.push_back(cell_px(18, 0, 24'hFFFF00));
    run_stream();
    wait_done("one_row", t0, FULL_LAT, 1);
    vecs.push_back(cell_px(19, 0, 24'hFFFF00));
    for (int c = 1; c < COLS; c++) vecs.push_back(cell_px(19, c, 24'h000000));
    run_stream();
    expect_rows_empty(0, 18);

    // Two full rows straddling a partial one; a write during the sequence must be dropped.
    do_reset();
    for (int c = 0; c < COLS; c++) begin write_cell(17, c, 6); write_cell(19, c, 6); end
    write_cell(18, 3, 4);
    pulse_start(t0);
    write_cell(0, 0, 7);
    wait_done("two_rows", t0, FULL_LAT, 2);
    vecs.push_back(cell_px(19, 3, 24'h00FF00));
    vecs.push_back(cell_px(19, 0, 24'h000000));
    vecs.push_back(cell_px(19, 9, 24'h000000));
    run_stream();
    expect_rows_empty(0, 18);

    pulse_start(t0);
    wait_done("no_full", t0, ROWS, 0);
    vecs.push_back(cell_px(19, 3, 24'h00FF00));
    run_stream();

    // Write and start in the same idle cycle: the scan must see the write.
    do_reset();
    for (int c = 0; c < COLS - 1; c++) write_cell(19, c, 2);
    @(negedge Clk);
    wr_en = 1'b1; wr_row = 5'd19; wr_col = 4'd9; wr_code = 3'd2; clear_start = 1'b1;
    @(negedge Clk);
    wr_en = 1'b0; clear_start = 1'b0;
    t0 = cyc;
    wait_done("same_cycle", t0, FULL_LAT, 1);
    vecs.push_back(cell_px(19, 9, 24'h000000));
    run_stream();

    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) write_cell(r, c, (r + c) % 7 + 1);
    pulse_start(t0);
    wait_done("all_full", t0, FULL_LAT, ROWS);
    expect_rows_empty(0, ROWS - 1);

    // Reset landing in the middle of the collapse.
    do_reset();
    for (int c = 0; c < COLS; c++) write_cell(19, c, 5);
    write_cell(10, 0, 3);
    pulse_start(t0);
    while (cyc - t0 < 2 * ROWS - 9) @(negedge Clk);
    check("mid_busy", clear_busy, 1);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_busy", clear_busy, 0);
    check("mid_rst_lines", lines_cleared, 0);
    Reset = 1'b0;
    expect_rows_empty(0, ROWS - 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
